// File: rtl/axis_fifo_gen_pkg.sv
// Shared types and sizing helpers for the axis_fifo_gen stream buffer.
package axis_fifo_gen_pkg;

   typedef enum logic {
      MODE_STREAM = 1'b0,
      MODE_PACKET = 1'b1
   } fifo_mode_t;

   // Counter/pointer width: one extra bit so that DEPTH itself is representable.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Stored word width; disabled sideband fields take no RAM bits.
   function automatic int unsigned word_width(input int unsigned dw,
                                              input int unsigned uw,
                                              input bit          keep_en,
                                              input bit          last_en,
                                              input bit          user_en);
      int unsigned w;
      w = dw;
      if (keep_en) w = w + dw / 8;
      if (last_en) w = w + 1;
      if (user_en) w = w + uw;
      return w;
   endfunction

endpackage

// File: rtl/axis_fifo_gen_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module axis_fifo_gen_ram
   import axis_fifo_gen_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned ENTRIES = 2 ** AW;

   logic [WIDTH-1:0] mem_q [ENTRIES];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo_gen.sv
// AXI-Stream FIFO with optional sideband, occupancy/packet counters, threshold flags
// and a store-and-forward packet mode.
module axis_fifo_gen
   import axis_fifo_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned USER_WIDTH = 1,
   parameter bit          KEEP_EN    = 1'b1,
   parameter bit          LAST_EN    = 1'b1,
   parameter bit          USER_EN    = 1'b0,
   parameter fifo_mode_t  MODE       = MODE_STREAM,
   parameter int unsigned AF_THRESH  = DEPTH - 4,
   parameter int unsigned AE_THRESH  = 4,
   localparam int unsigned CW        = cnt_width(DEPTH),
   localparam int unsigned KW        = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KW-1:0]         s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KW-1:0]         m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [CW-1:0]         fifo_count,
   output logic [CW-1:0]         pkt_count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  fifo_almost_empty,
   output logic                  fifo_almost_full
);

   localparam int unsigned AW   = CW - 1;
   localparam int unsigned WW   = word_width(DATA_WIDTH, USER_WIDTH, KEEP_EN, LAST_EN, USER_EN);
   localparam int unsigned KOFF = DATA_WIDTH;
   localparam int unsigned LOFF = KOFF + (KEEP_EN ? KW : 0);
   localparam int unsigned UOFF = LOFF + (LAST_EN ? 1 : 0);

   if (MODE == MODE_PACKET && !LAST_EN) begin : g_bad_cfg
      $error("axis_fifo_gen: MODE_PACKET requires LAST_EN=1");
   end

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pkt_q, pkt_d;
   logic          tready_q, tready_d;

   logic          wr_c, rd_c;
   logic          s_last_c, m_last_c;
   logic          m_valid_c;
   logic [WW-1:0] wr_word_c, rd_word_c;

   // Sideband packing into the RAM word; disabled fields are neither stored nor read.
   assign wr_word_c[DATA_WIDTH-1:0] = s_axis_tdata;
   assign m_axis_tdata              = rd_word_c[DATA_WIDTH-1:0];

   if (KEEP_EN) begin : g_keep
      assign wr_word_c[LOFF-1:KOFF] = s_axis_tkeep;
      assign m_axis_tkeep           = rd_word_c[LOFF-1:KOFF];
   end else begin : g_no_keep
      logic unused_keep_c;
      assign unused_keep_c = ^s_axis_tkeep;
      assign m_axis_tkeep  = '1;
   end

   if (LAST_EN) begin : g_last
      assign wr_word_c[LOFF] = s_axis_tlast;
      assign m_last_c        = rd_word_c[LOFF];
      assign s_last_c        = s_axis_tlast;
   end else begin : g_no_last
      logic unused_last_c;
      assign unused_last_c = s_axis_tlast;
      assign m_last_c      = 1'b0;
      assign s_last_c      = 1'b0;
   end

   if (USER_EN) begin : g_user
      assign wr_word_c[WW-1:UOFF] = s_axis_tuser;
      assign m_axis_tuser         = rd_word_c[WW-1:UOFF];
   end else begin : g_no_user
      logic unused_user_c;
      assign unused_user_c = ^s_axis_tuser;
      assign m_axis_tuser  = '0;
   end

   assign m_axis_tlast = m_last_c;

   axis_fifo_gen_ram #(
      .WIDTH (WW),
      .AW    (AW)
   ) u_ram (
      .clk     (aclk),
      .we_i    (wr_c),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_word_c),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_word_c)
   );

   // Output valid depends on registered counts only; packet mode waits for a stored tlast
   // unless the FIFO is full, which lets an oversize packet cut through instead of deadlocking.
   always_comb begin
      m_valid_c = 1'b0;
      if (MODE == MODE_PACKET) begin
         m_valid_c = (count_q != '0) && ((pkt_q != '0) || (count_q == CW'(DEPTH)));
      end else begin
         m_valid_c = (count_q != '0);
      end
   end

   assign wr_c = s_axis_tvalid & tready_q;
   assign rd_c = m_valid_c & m_axis_tready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_c) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_c) rd_ptr_d = rd_ptr_q + CW'(1);
      count_d  = count_q + CW'(wr_c) - CW'(rd_c);
      pkt_d    = pkt_q + CW'(wr_c & s_last_c) - CW'(rd_c & m_last_c);
      tready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pkt_q    <= '0;
         tready_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         tready_q <= tready_d;
      end
   end

   // Wrap bits only keep the pointers aligned with the counts; addressing uses the low bits.
   logic unused_wrap_c;
   assign unused_wrap_c = wr_ptr_q[CW-1] ^ rd_ptr_q[CW-1];

   assign s_axis_tready     = tready_q;
   assign m_axis_tvalid     = m_valid_c;
   assign fifo_count        = count_q;
   assign pkt_count         = pkt_q;
   assign fifo_empty        = (count_q == '0);
   assign fifo_full         = (count_q == CW'(DEPTH));
   assign fifo_almost_empty = (count_q <= CW'(AE_THRESH));
   assign fifo_almost_full  = (count_q >= CW'(AF_THRESH));

endmodule

// File: tb/tb_axis_fifo_gen.sv
// Bench for axis_fifo_gen: a stream-mode and a packet-mode instance checked against a queue model.
module tb_axis_fifo_gen;
   import axis_fifo_gen_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned AF    = 6;
   localparam int unsigned AE    = 1;

   typedef struct packed {
      logic        last;
      logic [3:0]  keep;
      logic [31:0] data;
   } beat_t;

   logic        clk;
   logic        rst     [2];
   logic [31:0] s_tdata [2];
   logic [3:0]  s_tkeep [2];
   logic        s_tlast [2];
   logic [0:0]  s_tuser [2];
   logic        s_tvalid[2];
   logic        s_tready[2];
   logic [31:0] m_tdata [2];
   logic [3:0]  m_tkeep [2];
   logic        m_tlast [2];
   logic [0:0]  m_tuser [2];
   logic        m_tvalid[2];
   logic        m_tready[2];
   logic [3:0]  f_count [2];
   logic [3:0]  p_count [2];
   logic        f_empty [2];
   logic        f_full  [2];
   logic        f_ae    [2];
   logic        f_af    [2];

   int    total = 0;
   int    bad   = 0;
   beat_t q[$];
   bit    rdy_ok = 1'b0;
   int    writes = 0;
   int    reads  = 0;
   int    next_data = 0;

   axis_fifo_gen #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .USER_WIDTH (1),
      .KEEP_EN (1'b1), .LAST_EN (1'b1), .USER_EN (1'b0),
      .MODE (MODE_STREAM), .AF_THRESH (AF), .AE_THRESH (AE)
   ) u_stream (
      .aclk (clk), .areset (rst[0]),
      .s_axis_tdata (s_tdata[0]), .s_axis_tkeep (s_tkeep[0]), .s_axis_tlast (s_tlast[0]),
      .s_axis_tuser (s_tuser[0]), .s_axis_tvalid (s_tvalid[0]), .s_axis_tready (s_tready[0]),
      .m_axis_tdata (m_tdata[0]), .m_axis_tkeep (m_tkeep[0]), .m_axis_tlast (m_tlast[0]),
      .m_axis_tuser (m_tuser[0]), .m_axis_tvalid (m_tvalid[0]), .m_axis_tready (m_tready[0]),
      .fifo_count (f_count[0]), .pkt_count (p_count[0]),
      .fifo_empty (f_empty[0]), .fifo_full (f_full[0]),
      .fifo_almost_empty (f_ae[0]), .fifo_almost_full (f_af[0])
   );

   axis_fifo_gen #(
      .DATA_WIDTH (DW), .DEPTH (DEPTH), .USER_WIDTH (1),
      .KEEP_EN (1'b1), .LAST_EN (1'b1), .USER_EN (1'b0),
      .MODE (MODE_PACKET), .AF_THRESH (AF), .AE_THRESH (AE)
   ) u_packet (
      .aclk (clk), .areset (rst[1]),
      .s_axis_tdata (s_tdata[1]), .s_axis_tkeep (s_tkeep[1]), .s_axis_tlast (s_tlast[1]),
      .s_axis_tuser (s_tuser[1]), .s_axis_tvalid (s_tvalid[1]), .s_axis_tready (s_tready[1]),
      .m_axis_tdata (m_tdata[1]), .m_axis_tkeep (m_tkeep[1]), .m_axis_tlast (m_tlast[1]),
      .m_axis_tuser (m_tuser[1]), .m_axis_tvalid (m_tvalid[1]), .m_axis_tready (m_tready[1]),
      .fifo_count (f_count[1]), .pkt_count (p_count[1]),
      .fifo_empty (f_empty[1]), .fifo_full (f_full[1]),
      .fifo_almost_empty (f_ae[1]), .fifo_almost_full (f_af[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare one DUT against the model, then apply one clock of stimulus to it.
   task automatic step(input int i, input bit sv, input bit sl, input bit mr);
      int    lasts;
      int    occ;
      bit    exp_valid, exp_ready, wr, rd;
      beat_t nb;
      lasts = 0;
      foreach (q[k]) lasts += int'(q[k].last);
      occ       = q.size();
      exp_valid = (occ != 0) && ((i == 0) || (lasts != 0) || (occ == int'(DEPTH)));
      exp_ready = rdy_ok && (occ != int'(DEPTH));
      check("count",  64'(f_count[i]),  64'(occ));
      check("pkts",   64'(p_count[i]),  64'(lasts));
      check("tvalid", 64'(m_tvalid[i]), 64'(exp_valid));
      check("tready", 64'(s_tready[i]), 64'(exp_ready));
      check("empty",  64'(f_empty[i]),  64'(occ == 0));
      check("full",   64'(f_full[i]),   64'(occ == int'(DEPTH)));
      check("afull",  64'(f_af[i]),     64'(occ >= int'(AF)));
      check("aempty", 64'(f_ae[i]),     64'(occ <= int'(AE)));
      check("tuser",  64'(m_tuser[i]),  64'(0));
      if (exp_valid) begin
         check("tdata", 64'(m_tdata[i]), 64'(q[0].data));
         check("tkeep", 64'(m_tkeep[i]), 64'(q[0].keep));
         check("tlast", 64'(m_tlast[i]), 64'(q[0].last));
      end
      nb.data = 32'(next_data);
      nb.keep = 4'($urandom);
      nb.last = sl;
      s_tvalid[i] = sv;
      s_tdata[i]  = nb.data;
      s_tkeep[i]  = nb.keep;
      s_tlast[i]  = sl;
      m_tready[i] = mr;
      wr = sv && exp_ready;
      rd = exp_valid && mr;
      @(posedge clk);
      if (rd) begin
         void'(q.pop_front());
         reads++;
      end
      if (wr) begin
         q.push_back(nb);
         writes++;
         next_data++;
      end
      rdy_ok = 1'b1;
      @(negedge clk);
   endtask

   // Hold reset for n clocks with the slave side offering data; check the reset state each clock.
   task automatic do_reset(input int i, input int n);
      rst[i]      = 1'b1;
      s_tvalid[i] = 1'b1;
      m_tready[i] = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_tready", 64'(s_tready[i]), 64'(0));
         check("rst_tvalid", 64'(m_tvalid[i]), 64'(0));
         check("rst_count",  64'(f_count[i]),  64'(0));
         check("rst_pkts",   64'(p_count[i]),  64'(0));
         check("rst_empty",  64'(f_empty[i]),  64'(1));
         check("rst_full",   64'(f_full[i]),   64'(0));
      end
      q.delete();
      rdy_ok = 1'b0;
      rst[i] = 1'b0;
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; s_tvalid[i] = 1'b0; m_tready[i] = 1'b0;
         s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 1'b0; s_tuser[i] = '0;
      end
      @(negedge clk);

      // Reset with valid held high; ready appears one clock after release.
      do_reset(0, 3);
      step(0, 1'b1, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0, 1'b0);

      // Fill to full with the master stalled, then drain in order.
      next_data = 0; writes = 0; guard = 0;
      while (writes < 8 && guard < 20) begin
         step(0, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      check("fill_writes", 64'(writes), 64'(8));
      step(0, 1'b1, 1'b0, 1'b0);
      repeat (10) step(0, 1'b0, 1'b0, 1'b1);

      // Both sides always ready: one beat per clock, occupancy stays at one.
      next_data = 0; writes = 0; reads = 0;
      repeat (100) step(0, 1'b1, 1'($urandom), 1'b1);
      check("thru_reads", 64'(reads), 64'(99));
      repeat (2) step(0, 1'b0, 1'b0, 1'b1);
      check("thru_total", 64'(reads), 64'(100));

      // Random handshakes, pointer wrap many times over.
      writes = 0; reads = 0; guard = 0;
      while (writes < 500 && guard < 5000) begin
         step(0, 1'($urandom), 1'($urandom), 1'($urandom));
         guard++;
      end
      check("rand_writes", 64'(writes), 64'(500));
      guard = 0;
      while (q.size() != 0 && guard < 50) begin
         step(0, 1'b0, 1'b0, 1'b1);
         guard++;
      end
      step(0, 1'b0, 1'b0, 1'b1);
      check("rand_reads", 64'(reads), 64'(500));

      // Packet mode: a 3-beat packet is held back until its tlast is stored.
      do_reset(1, 2);
      step(1, 1'b0, 1'b0, 1'b1);
      step(1, 1'b1, 1'b0, 1'b1);
      step(1, 1'b1, 1'b0, 1'b1);
      step(1, 1'b1, 1'b1, 1'b1);
      repeat (5) step(1, 1'b0, 1'b0, 1'b1);

      // Packet mode: a 10-beat packet outgrows the FIFO and cuts through once full.
      writes = 0; reads = 0; guard = 0;
      while (writes < 10 && guard < 100) begin
         step(1, 1'b1, (writes == 9), 1'b1);
         guard++;
      end
      check("big_writes", 64'(writes), 64'(10));
      repeat (12) step(1, 1'b0, 1'b0, 1'b1);
      check("big_reads", 64'(reads), 64'(10));

      // Reset in the middle of a packet discards it.
      writes = 0; guard = 0;
      while (writes < 4 && guard < 20) begin
         step(1, 1'b1, 1'b0, 1'b0);
         guard++;
      end
      check("abort_writes", 64'(writes), 64'(4));
      do_reset(1, 1);
      step(1, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
